// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Brief    : Stereo I2S transmitter. Accepts signed left/right sample pairs
//            over valid/ready into a one-entry holding register and
//            serialises them MSB-first to an I2S DAC. BCLK and LRCLK are
//            derived from audio_clk.
//            Optional macro I2S_TX_UNDERRUN_HOLD_EN: on underrun the previous
//            pair is retransmitted instead of silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 16
) (
    input  logic                    audio_clk,
    input  logic                    rst_in_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(2 * SLOT_WIDTH);

    logic [c_DIV_W-1:0]      r_div_cnt;
    logic                    r_bclk;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic                    r_lrclk;
    logic                    r_sdata;
    logic                    r_hold_empty;
    logic [SAMPLE_WIDTH-1:0] r_hold_l;
    logic [SAMPLE_WIDTH-1:0] r_hold_r;
    logic [SAMPLE_WIDTH-1:0] r_act_l;
    logic [SAMPLE_WIDTH-1:0] r_act_r;
    logic                    r_frame_start;
    logic                    r_underrun;

    logic                    w_div_tc;
    logic                    w_fall;
    logic [c_BIT_W-1:0]      w_b;
    logic                    w_right;
    logic [c_BIT_W-1:0]      w_p;
    logic [SAMPLE_WIDTH-1:0] w_sel;
    logic                    w_bit;
    logic                    w_load;
    logic                    w_xfer;

    // Tick decode, next bit position and the serial bit for that position
    always_comb begin
        w_div_tc = (r_div_cnt == c_DIV_W'(BCLK_DIV - 1));
        w_fall   = w_div_tc && r_bclk;
        w_b      = (r_bit_cnt == c_BIT_W'(2 * SLOT_WIDTH - 1)) ? '0
                                                               : r_bit_cnt + c_BIT_W'(1);
        w_right  = (w_b >= c_BIT_W'(SLOT_WIDTH));
        w_p      = w_right ? (w_b - c_BIT_W'(SLOT_WIDTH)) : w_b;
        w_sel    = w_right ? r_act_r : r_act_l;
        // Slot position p carries sample bit SAMPLE_WIDTH-p; positions
        // outside 1..SAMPLE_WIDTH are zero padding.
        w_bit    = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (w_p == c_BIT_W'(SAMPLE_WIDTH - i)) begin
                w_bit = w_sel[i];
            end
        end
        w_load   = w_fall && (w_b == '0);
        w_xfer   = sample_valid && r_hold_empty;
    end

    // BCLK divider: toggle BCLK every BCLK_DIV audio_clk cycles
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    // Frame bit counter, word select and serial data, all updated on fall ticks
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_bit_cnt <= c_BIT_W'(2 * SLOT_WIDTH - 1);
            r_lrclk   <= 1'b1;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_b;
            r_lrclk   <= w_right;
            r_sdata   <= w_bit;
        end
    end

    // One-entry holding register: filled by handshake, drained by frame load
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_hold_empty <= 1'b1;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
        end else if (w_xfer) begin
            r_hold_empty <= 1'b0;
            r_hold_l     <= sample_left;
            r_hold_r     <= sample_right;
        end else if (w_load && !r_hold_empty) begin
            r_hold_empty <= 1'b1;
        end
    end

    // Frame load into the active registers plus frame_start/underrun pulses
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_act_l       <= '0;
            r_act_r       <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else if (w_load) begin
            r_frame_start <= 1'b1;
            if (!r_hold_empty) begin
                r_act_l    <= r_hold_l;
                r_act_r    <= r_hold_r;
                r_underrun <= 1'b0;
            end else begin
                r_underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                // Active registers keep the previous pair so it is repeated
`else
                r_act_l    <= '0;
                r_act_r    <= '0;
`endif
            end
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end
    end

    assign sample_ready = r_hold_empty;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_sdata    = r_sdata;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Brief    : Self-checking bench for i2s_tx. A frame-level model predicts all
//            outputs from the cycle count since reset release; a DAC-style
//            decoder recovers the transmitted words for literal checks.
//            Honours I2S_TX_UNDERRUN_HOLD_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int SW    = 16;
    localparam int S     = 32;
    localparam int D     = 16;
    localparam int FRAME = 4 * D * S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [SW-1:0] sample_left = '0;
    logic [SW-1:0] sample_right = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          frame_start;
    logic          underrun;

    i2s_tx #(
        .SAMPLE_WIDTH (SW),
        .SLOT_WIDTH   (S),
        .BCLK_DIV     (D)
    ) dut (
        .audio_clk    (clk),
        .rst_in_n     (rst_n),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            n = 0;           // rising edges since reset release
    bit            hold_full = 0;
    logic [SW-1:0] hl = '0, hr = '0;
    logic [SW-1:0] fl [64];
    logic [SW-1:0] fr [64];
    bit            und [64];

    initial begin
        for (int i = 0; i < 64; i++) begin fl[i] = '0; fr[i] = '0; und[i] = 0; end
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n = 0; hold_full = 0; hl = '0; hr = '0;
            end else begin
                bit pre;
                pre = hold_full;
                n++;
                if (n >= 2 * D && (n - 2 * D) % FRAME == 0) begin
                    int k;
                    k = (n - 2 * D) / FRAME;
                    if (k < 64) begin
                        if (pre) begin
                            fl[k] = hl; fr[k] = hr; und[k] = 0; hold_full = 0;
                        end else begin
                            und[k] = 1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                            fl[k] = (k > 0) ? fl[k-1] : '0;
                            fr[k] = (k > 0) ? fr[k-1] : '0;
`else
                            fl[k] = '0;
                            fr[k] = '0;
`endif
                        end
                    end
                end
                if (sample_valid && !pre) begin
                    hl = sample_left; hr = sample_right; hold_full = 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_bclk",  32'(i2s_bclk),     0);
                chk("rst_lrclk", 32'(i2s_lrclk),    1);
                chk("rst_sdata", 32'(i2s_sdata),    0);
                chk("rst_ready", 32'(sample_ready), 1);
                chk("rst_fs",    32'(frame_start),  0);
                chk("rst_ur",    32'(underrun),     0);
            end else begin
                int f, b, k, p;
                logic [SW-1:0] w;
                bit e_lr, e_sd, e_fs, e_ur;
                f = n / (2 * D);
                if (f == 0) begin
                    e_lr = 1; e_sd = 0;
                end else begin
                    b = (f - 1) % (2 * S);
                    k = (f - 1) / (2 * S);
                    e_lr = (b >= S);
                    p = b % S;
                    w = e_lr ? fr[k] : fl[k];
                    e_sd = (p >= 1 && p <= SW) ? w[SW-p] : 1'b0;
                end
                e_fs = (n >= 2 * D) && ((n - 2 * D) % FRAME == 0);
                e_ur = e_fs && und[(n - 2 * D) / FRAME];
                chk("bclk",   32'(i2s_bclk),     32'((n / D) % 2));
                chk("lrclk",  32'(i2s_lrclk),    32'(e_lr));
                chk("sdata",  32'(i2s_sdata),    32'(e_sd));
                chk("ready",  32'(sample_ready), 32'(!hold_full));
                chk("fstart", 32'(frame_start),  32'(e_fs));
                chk("underr", 32'(underrun),     32'(e_ur));
            end
        end
    end

    // ---------------- DAC-style decoder and pulse counters ----------------
    logic [SW-1:0] dec_l [$];
    logic [SW-1:0] dec_r [$];
    int fs_cnt = 0, ur_cnt = 0;

    initial begin
        logic          prev_b, prev_lr;
        logic [SW-1:0] sh;
        int            pos;
        prev_b = 0; prev_lr = 1; pos = 100; sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dec_l.delete(); dec_r.delete();
                fs_cnt = 0; ur_cnt = 0;
                prev_b = 0; prev_lr = 1; pos = 100;
            end else begin
                if (frame_start) fs_cnt++;
                if (underrun)    ur_cnt++;
                if (i2s_bclk && !prev_b) begin
                    if (i2s_lrclk !== prev_lr) pos = 0;
                    else if (pos < 100) pos++;
                    prev_lr = i2s_lrclk;
                    if (pos >= 1 && pos <= SW) sh = (sh << 1) | SW'(i2s_sdata);
                    if (pos == SW) begin
                        if (i2s_lrclk) dec_r.push_back(sh);
                        else           dec_l.push_back(sh);
                    end
                end
                prev_b = i2s_bclk;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (n < target) begin
            miscompares++;
            $display("FAIL wait_n: got n=%0d expected %0d (timeout)", n, target);
        end
    endtask

    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
        bit acc;
        int guard;
        sample_valid = 1'b1; sample_left = l; sample_right = r;
        acc = 0; guard = 0;
        while (!acc && guard < 5000) begin
            @(negedge clk);
            acc = sample_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            miscompares++;
            $display("FAIL send: got no accept expected accept within 5000 cycles");
        end
    endtask

    logic [SW-1:0] cont_l [8];
    logic [SW-1:0] cont_r [8];
    logic [SW-1:0] starve_l, starve_r;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle start-up: fixed timing landmarks
        wait_n(15);
        chk("bclk_before_rise", 32'(i2s_bclk), 0);
        wait_n(16);
        chk("bclk_first_rise", 32'(i2s_bclk), 1);
        wait_n(32);
        chk("first_fs", 32'(frame_start), 1);
        chk("first_ur", 32'(underrun), 1);
        chk("first_lrclk", 32'(i2s_lrclk), 0);
        wait_n(1500);
        chk("idle_left_count", 32'(dec_l.size()), 1);
        chk("idle_left_word", 32'(dec_l[0]), 0);

        // Reset in the middle of the right slot
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_bclk",  32'(i2s_bclk),     0);
        chk("midrst_lrclk", 32'(i2s_lrclk),    1);
        chk("midrst_sdata", 32'(i2s_sdata),    0);
        chk("midrst_ready", 32'(sample_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Known pair before the first load, then a continuous source
        send(16'hA5C3, 16'h8001);
        for (int i = 0; i < 8; i++) begin
            cont_l[i] = 16'($urandom);
            cont_r[i] = 16'($urandom);
            send(cont_l[i], cont_r[i]);
        end
        send(16'h1234, 16'hFEDC);
        sample_valid = 1'b0;

        // Two starved frames follow the last pair
        wait_n(2 * D + 11 * FRAME + 10);
        chk("fs_count", 32'(fs_cnt), 12);
        chk("ur_count", 32'(ur_cnt), 2);
        chk("dec_count", 32'(dec_l.size()), 11);
        chk("known_left",  32'(dec_l[0]), 32'h0000A5C3);
        chk("known_right", 32'(dec_r[0]), 32'h00008001);
        for (int i = 0; i < 8; i++) begin
            chk("cont_left",  32'(dec_l[1+i]), 32'(cont_l[i]));
            chk("cont_right", 32'(dec_r[1+i]), 32'(cont_r[i]));
        end
        chk("last_left",  32'(dec_l[9]), 32'h00001234);
        chk("last_right", 32'(dec_r[9]), 32'h0000FEDC);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        starve_l = 16'h1234; starve_r = 16'hFEDC;
`else
        starve_l = 16'h0000; starve_r = 16'h0000;
`endif
        chk("starve_left",  32'(dec_l[10]), 32'(starve_l));
        chk("starve_right", 32'(dec_r[10]), 32'(starve_r));

        // Sparse random source: mix of fed and starved frames
        for (int c = 0; c < 3 * FRAME; c++) begin
            sample_valid = ($urandom_range(0, 1199) == 0);
            sample_left  = 16'($urandom);
            sample_right = 16'($urandom);
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        repeat (FRAME + 100) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter, the output-side counterpart of the `i2s` mic receiver. It accepts 16-bit signed left/right sample pairs over a valid/ready handshake and serialises them to an external I2S DAC on a pmod header. It generates BCLK and LRCLK from `audio_clk` (98.304 MHz), so it replaces `pdm` as the speaker path. Defaults give 3.072 MHz BCLK, 64 BCLK per frame and 48 kHz frames.

## Interface
- `SAMPLE_WIDTH`, 16, bits per channel sample; must satisfy 1 ≤ `SAMPLE_WIDTH` < `SLOT_WIDTH`.
- `SLOT_WIDTH`, 32, BCLK periods per channel slot; a frame is 2·`SLOT_WIDTH`.
- `BCLK_DIV`, 16, `audio_clk` cycles per BCLK half-period; minimum 2.

- `audio_clk`  in  1  sole clock, rising-edge.
- `rst_in_n`  in  1  asynchronous, active-low reset.
- `sample_left`  in  SAMPLE_WIDTH  signed left sample.
- `sample_right`  in  SAMPLE_WIDTH  signed right sample.
- `sample_valid`  in  1  pair presented.
- `sample_ready`  out  1  holding register empty.
- `i2s_bclk`  out  1  bit clock to DAC.
- `i2s_lrclk`  out  1  word select: 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data, MSB first.
- `frame_start`  out  1  one-cycle pulse when a frame is loaded.
- `underrun`  out  1  one-cycle pulse when a frame loads with the holding register empty.

## Operation
- A pair transfers on any cycle with `sample_valid && sample_ready`. Both samples are captured into a one-entry holding register, which sets `hold_full`.
- `sample_ready` = `!hold_full`, driven from a register and independent of `sample_valid`.
- Divider: `div_cnt` counts 0..`BCLK_DIV`-1. At terminal count the BCLK register toggles and `div_cnt` returns to 0.
- Fall tick: the cycle in which the BCLK register is updated from 1 to 0.
- On each fall tick, `bit_cnt` advances modulo 2·`SLOT_WIDTH`. Call the new value b.
- On each fall tick, `i2s_lrclk` is set to (b ≥ `SLOT_WIDTH`).
- On each fall tick, with p = b mod `SLOT_WIDTH`, `i2s_sdata` is set to:
  - active[`SAMPLE_WIDTH`-p] when 1 ≤ p ≤ `SAMPLE_WIDTH`;
  - 0 otherwise.
  - active is the left register when b < `SLOT_WIDTH`, otherwise the right register.
- This produces standard I2S framing: MSB one BCLK after the LRCLK edge, zero padding after the LSB.
- Frame load happens on the fall tick where b becomes 0:
  - If `hold_full`: the active registers take the holding contents, `hold_full` clears and `frame_start` pulses.
  - If the holding register is empty: `frame_start` and `underrun` both pulse, and the active registers load zeros. With the configuration macro defined, the active registers keep their previous contents instead.
- Handshake and frame load cannot collide. A transfer requires `hold_full` = 0 and a load consumes only when `hold_full` = 1. In the load cycle `sample_ready` is still 0, and it rises on the following cycle.
- Arithmetic: samples pass through bit-exact. No scaling, truncation or sign extension is applied.

## Timing
- Reset values:
  - `i2s_bclk` = 0
  - `i2s_lrclk` = 1
  - `i2s_sdata` = 0
  - `sample_ready` = 1
  - `frame_start` = 0
  - `underrun` = 0
  - `div_cnt` = 0
  - `bit_cnt` = 2·`SLOT_WIDTH`-1
  - active and holding registers = 0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The first BCLK rise is `BCLK_DIV` cycles after reset deassertion. The first fall tick is at 2·`BCLK_DIV` cycles and is the first frame load.
- BCLK period = 2·`BCLK_DIV` cycles. Frame period = 4·`BCLK_DIV`·`SLOT_WIDTH` cycles (2048 with defaults).
- Data and LRCLK change only on fall ticks, so the DAC samples on the BCLK rise with `BCLK_DIV` cycles of setup.
- Latency: a pair accepted before a frame load has its left MSB on `i2s_sdata` one BCLK period (2·`BCLK_DIV` cycles) after that load. A pair accepted in the load cycle itself misses that load and waits one full frame.
- Holding register full: the source stalls for up to one frame period.
- Reset mid-frame: every register returns to its reset value immediately. BCLK stops low and LRCLK high, and the in-flight frame and holding contents are discarded.

## Configuration
- `I2S_TX_UNDERRUN_HOLD_EN`
  - Defined: on underrun the previous pair is retransmitted, which avoids clicks on the speaker during source stalls.
  - Undefined: the underrun frame is silence (all-zero data).
  - `underrun` pulses in both cases.

## Test plan
- Reset release, no input → BCLK rise at cycle 16, first fall tick at cycle 32; `frame_start` and `underrun` pulse together there, `i2s_sdata` stays 0 for the whole frame, `i2s_lrclk` low for 32 BCLK then high for 32 BCLK.
- Load left=16'hA5C3, right=16'h8001 before the first load → DAC model captures 0xA5C3 in the left slot and 0x8001 in the right slot, with 15 zero pad bits per slot and MSB one BCLK after each LRCLK edge.
- Continuous source with `sample_valid` held high, 8 distinct pairs → 8 consecutive frames decode in order, `underrun` never pulses, `sample_ready` drops within one cycle of each accept.
- Source stops after pair (16'h1234, 16'hFEDC) → next frame decodes as zeros, or as 0x1234/0xFEDC when `I2S_TX_UNDERRUN_HOLD_EN` is defined; `underrun` pulses exactly once per starved frame.
- `sample_valid` asserted in the exact load cycle with the holding register full → the held pair loads, the new pair is accepted one cycle later, and there is no loss or duplication.
- `rst_in_n` pulsed low mid-right-slot → outputs take reset values in the same cycle; after release the timing matches the first scenario.
